// File: rtl/wb_host_master.sv
// wb_host_master: Wishbone classic master fed by a valid/ready request FIFO.
// One bus cycle outstanding at a time; every request returns exactly one
// response carrying read data, a bus error flag or a timeout flag.
module wb_host_master #(
    parameter int unsigned BUS_WIDTH   = 32,
    parameter int unsigned BUS_MASK    = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // request side
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [BUS_WIDTH-1:0] req_addr_i,
    input  logic                 req_we_i,
    input  logic [BUS_WIDTH-1:0] req_data_i,
    input  logic [BUS_MASK-1:0]  req_sel_i,
    // response side
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [BUS_WIDTH-1:0] resp_data_o,
    output logic                 resp_err_o,
    output logic                 resp_tmo_o,
    // Wishbone master port
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic [BUS_WIDTH-1:0] wb_addr_o,
    output logic                 wb_we_o,
    output logic [BUS_WIDTH-1:0] wb_data_o,
    output logic [BUS_MASK-1:0]  wb_sel_o,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    input  logic [BUS_WIDTH-1:0] wb_data_i,
    // status
    output logic                 busy_o
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = (TIMEOUT_CYC >= 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    typedef struct packed {
        logic [BUS_WIDTH-1:0] addr;
        logic                 we;
        logic [BUS_WIDTH-1:0] data;
        logic [BUS_MASK-1:0]  sel;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // request FIFO
    req_t           r_mem [FIFO_DEPTH];
    logic [AW:0]    r_wptr;
    logic [AW:0]    r_rptr;
    logic           w_empty;
    logic           w_full;
    logic           w_push;
    logic           w_pop;
    req_t           w_push_req;
    req_t           w_head;

    // control
    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_done;
    logic           w_tmo;
    logic [CNT_W-1:0] r_cnt;

    // bus and response registers
    logic                 r_cyc;
    logic [BUS_WIDTH-1:0] r_addr;
    logic                 r_we;
    logic [BUS_WIDTH-1:0] r_wdata;
    logic [BUS_MASK-1:0]  r_sel;
    logic [BUS_WIDTH-1:0] r_resp_data;
    logic                 r_resp_err;
    logic                 r_resp_tmo;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) &&
                        (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push     = req_valid_i && !w_full;
    assign w_push_req = '{addr: req_addr_i, we: req_we_i, data: req_data_i, sel: req_sel_i};
    assign w_head     = r_mem[r_rptr[AW-1:0]];

    // Timeout fires on the last allowed BUS cycle; disabled when TIMEOUT_CYC is 0.
    assign w_tmo = (TIMEOUT_CYC != 0) && (r_cnt == CNT_W'(TMO_LAST));

    // FIFO storage write; entries need no reset because the pointers gate them.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_push_req;
        end
    end

    // FIFO pointer update; reset flushes all queued requests.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: pop in IDLE, terminate in BUS, hand over response in RESP.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wb_ack_i || wb_err_i || w_tmo) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus cycle launch/termination, wait counter and response capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cyc       <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_resp_tmo  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_cyc   <= 1'b1;
                r_addr  <= w_head.addr;
                r_we    <= w_head.we;
                r_wdata <= w_head.data;
                r_sel   <= w_head.sel;
                r_cnt   <= '0;
            end else if (r_state == ST_BUS) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // err beats ack, and a real termination beats the timeout
            if (w_done) begin
                r_cyc       <= 1'b0;
                r_resp_err  <= wb_err_i;
                r_resp_tmo  <= !wb_ack_i && !wb_err_i;
                r_resp_data <= (wb_ack_i && !wb_err_i && !r_we) ? wb_data_i : '0;
            end
        end
    end

    assign req_ready_o  = !w_full;
    assign resp_valid_o = (r_state == ST_RESP);
    assign resp_data_o  = r_resp_data;
    assign resp_err_o   = r_resp_err;
    assign resp_tmo_o   = r_resp_tmo;
    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = r_cyc;
    assign wb_addr_o    = r_addr;
    assign wb_we_o      = r_we;
    assign wb_data_o    = r_wdata;
    assign wb_sel_o     = r_sel;
    assign busy_o       = !w_empty || (r_state != ST_IDLE);

endmodule
